mips_cpu_datapath_core: RTL and testbench



---
 rtl/mips_cpu_pkg.sv | 37 +++
 rtl/mips_cpu_regfile.sv | 35 +++
 rtl/mips_cpu_datapath_core.sv | 106 ++++++++++
 tb/tb_mips_cpu_datapath_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the multicycle MIPS datapath core.
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_NOR  = 4'b0011,
        ALU_ADD  = 4'b0100,
        ALU_SUB  = 4'b0101,
        ALU_SLT  = 4'b0110,
        ALU_SLTU = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_SLLV = 4'b1011,
        ALU_SRLV = 4'b1100,
        ALU_SRAV = 4'b1101,
        ALU_LUI  = 4'b1110,
        ALU_NONE = 4'b1111
    } alu_op_t;

    typedef enum logic [2:0] {
        HILO_NONE  = 3'b000,
        HILO_MULT  = 3'b001,
        HILO_MULTU = 3'b010,
        HILO_DIV   = 3'b011,
        HILO_DIVU  = 3'b100,
        HILO_MTHI  = 3'b101,
        HILO_MTLO  = 3'b110
    } hilo_op_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/mips_cpu_regfile.sv
// 32x32 register file: two async read ports, one sync write port, $0 hardwired,
// live tap of register V0_INDEX. Reads have no write bypass.
module mips_cpu_regfile
    import mips_cpu_pkg::*;
#(
    parameter int         DATA_W   = 32,
    parameter logic [4:0] V0_INDEX = REG_V0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [4:0]        write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_addr_a,
    output logic [DATA_W-1:0] read_data_a,
    input  logic [4:0]        read_addr_b,
    output logic [DATA_W-1:0] read_data_b,
    output logic [DATA_W-1:0] register_v0
);

    logic [DATA_W-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (write_enable && write_addr != REG_ZERO) begin
            regs[write_addr] <= write_data;
        end
    end

    assign read_data_a = (read_addr_a == REG_ZERO) ? '0 : regs[read_addr_a];
    assign read_data_b = (read_addr_b == REG_ZERO) ? '0 : regs[read_addr_b];
    assign register_v0 = (V0_INDEX == REG_ZERO)    ? '0 : regs[V0_INDEX];

endmodule

// File: rtl/mips_cpu_datapath_core.sv
// Execute/storage core: register file plus combinational ALU.
// Define MIPS_CPU_HILO_EN to add HI/LO multiply/divide registers and their ports.
module mips_cpu_datapath_core
    import mips_cpu_pkg::*;
#(
    parameter int         DATA_W   = 32,
    parameter logic [4:0] V0_INDEX = REG_V0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [4:0]        alu_sa,
    output logic [DATA_W-1:0] alu_r,
    output logic              alu_zero,
    input  logic              rf_write_enable,
    input  logic [4:0]        rf_write_addr,
    input  logic [DATA_W-1:0] rf_write_data,
    input  logic [4:0]        rf_read_addr_a,
    output logic [DATA_W-1:0] rf_read_data_a,
    input  logic [4:0]        rf_read_addr_b,
    output logic [DATA_W-1:0] rf_read_data_b,
`ifdef MIPS_CPU_HILO_EN
    input  logic [2:0]        hilo_op,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
`endif
    output logic [DATA_W-1:0] register_v0
);

    mips_cpu_regfile #(.DATA_W(DATA_W), .V0_INDEX(V0_INDEX)) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .write_enable (rf_write_enable),
        .write_addr   (rf_write_addr),
        .write_data   (rf_write_data),
        .read_addr_a  (rf_read_addr_a),
        .read_data_a  (rf_read_data_a),
        .read_addr_b  (rf_read_addr_b),
        .read_data_b  (rf_read_data_b),
        .register_v0  (register_v0)
    );

    logic [4:0] var_sa;
    assign var_sa = alu_a[4:0];

    always_comb begin
        alu_r = '0;
        case (alu_op_t'(alu_control))
            ALU_AND:  alu_r = alu_a & alu_b;
            ALU_OR:   alu_r = alu_a | alu_b;
            ALU_XOR:  alu_r = alu_a ^ alu_b;
            ALU_NOR:  alu_r = ~(alu_a | alu_b);
            ALU_ADD:  alu_r = alu_a + alu_b;
            ALU_SUB:  alu_r = alu_a - alu_b;
            ALU_SLT:  alu_r = {{(DATA_W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_r = {{(DATA_W-1){1'b0}}, alu_a < alu_b};
            ALU_SLL:  alu_r = alu_b << alu_sa;
            ALU_SRL:  alu_r = alu_b >> alu_sa;
            ALU_SRA:  alu_r = $signed(alu_b) >>> alu_sa;
            ALU_SLLV: alu_r = alu_b << var_sa;
            ALU_SRLV: alu_r = alu_b >> var_sa;
            ALU_SRAV: alu_r = $signed(alu_b) >>> var_sa;
            ALU_LUI:  alu_r = {alu_b[15:0], 16'h0000};
            ALU_NONE: alu_r = '0;
            default:  alu_r = '0;
        endcase
    end

    assign alu_zero = (alu_r == '0);

`ifdef MIPS_CPU_HILO_EN
    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic [DATA_W-1:0]   quot_s, rem_s, quot_u, rem_u;
    logic                div_by_zero;

    assign prod_s = $signed({{DATA_W{alu_a[DATA_W-1]}}, alu_a}) *
                    $signed({{DATA_W{alu_b[DATA_W-1]}}, alu_b});
    assign prod_u = {{DATA_W{1'b0}}, alu_a} * {{DATA_W{1'b0}}, alu_b};
    assign div_by_zero = (alu_b == '0);
    // Operand guard keeps the dividers from seeing zero; results are discarded then anyway.
    assign quot_s = div_by_zero ? '0 : $signed(alu_a) / $signed(alu_b);
    assign rem_s  = div_by_zero ? '0 : $signed(alu_a) % $signed(alu_b);
    assign quot_u = div_by_zero ? '0 : alu_a / alu_b;
    assign rem_u  = div_by_zero ? '0 : alu_a % alu_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            case (hilo_op_t'(hilo_op))
                HILO_MULT:  {hi, lo} <= prod_s;
                HILO_MULTU: {hi, lo} <= prod_u;
                HILO_DIV:   if (!div_by_zero) begin lo <= quot_s; hi <= rem_s; end
                HILO_DIVU:  if (!div_by_zero) begin lo <= quot_u; hi <= rem_u; end
                HILO_MTHI:  hi <= alu_a;
                HILO_MTLO:  lo <= alu_a;
                default:    ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mips_cpu_datapath_core.sv
// Directed bench: ALU vector table plus register-file and HI/LO sequences.
module tb_mips_cpu_datapath_core;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_sa;
    logic [31:0] alu_r;
    logic        alu_zero;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [4:0]  rf_read_addr_a, rf_read_addr_b;
    logic [31:0] rf_read_data_a, rf_read_data_b;
    logic [31:0] register_v0;
`ifdef MIPS_CPU_HILO_EN
    logic [2:0]  hilo_op;
    logic [31:0] hi, lo;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mips_cpu_datapath_core dut (
        .clk             (clk),
        .reset           (reset),
        .alu_control     (alu_control),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_sa          (alu_sa),
        .alu_r           (alu_r),
        .alu_zero        (alu_zero),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .rf_read_addr_a  (rf_read_addr_a),
        .rf_read_data_a  (rf_read_data_a),
        .rf_read_addr_b  (rf_read_addr_b),
        .rf_read_data_b  (rf_read_data_b),
`ifdef MIPS_CPU_HILO_EN
        .hilo_op         (hilo_op),
        .hi              (hi),
        .lo              (lo),
`endif
        .register_v0     (register_v0)
    );

    typedef struct {
        string       name;
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sa;
        logic [31:0] exp_r;
        logic        exp_zero;
    } alu_vec_t;

    alu_vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        rf_write_enable = 1'b1;
        rf_write_addr   = addr;
        rf_write_data   = data;
        tick();
        rf_write_enable = 1'b0;
    endtask

    initial begin
        vecs.push_back('{"and",       ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0});
        vecs.push_back('{"or",        ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0});
        vecs.push_back('{"xor",       ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0});
        vecs.push_back('{"nor",       ALU_NOR,  32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"add_wrap",  ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1});
        vecs.push_back('{"add",       ALU_ADD,  32'h00000003, 32'h00000004, 5'd0,  32'h00000007, 1'b0});
        vecs.push_back('{"sub_neg",   ALU_SUB,  32'h00000005, 32'h00000007, 5'd0,  32'hFFFFFFFE, 1'b0});
        vecs.push_back('{"sub_eq",    ALU_SUB,  32'h00000009, 32'h00000009, 5'd0,  32'h00000000, 1'b1});
        vecs.push_back('{"slt",       ALU_SLT,  32'h80000000, 32'h00000001, 5'd0,  32'h00000001, 1'b0});
        vecs.push_back('{"sltu",      ALU_SLTU, 32'h80000000, 32'h00000001, 5'd0,  32'h00000000, 1'b1});
        vecs.push_back('{"slt_rev",   ALU_SLT,  32'h00000001, 32'h80000000, 5'd0,  32'h00000000, 1'b1});
        vecs.push_back('{"sltu_rev",  ALU_SLTU, 32'h00000001, 32'h80000000, 5'd0,  32'h00000001, 1'b0});
        vecs.push_back('{"sll31",     ALU_SLL,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0});
        vecs.push_back('{"sll0",      ALU_SLL,  32'h00000000, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0});
        vecs.push_back('{"srl",       ALU_SRL,  32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 1'b0});
        vecs.push_back('{"sra",       ALU_SRA,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0});
        vecs.push_back('{"sra0",      ALU_SRA,  32'h00000000, 32'h80000001, 5'd0,  32'h80000001, 1'b0});
        vecs.push_back('{"sllv",      ALU_SLLV, 32'h00000024, 32'h00000001, 5'd9,  32'h00000010, 1'b0});
        vecs.push_back('{"srlv",      ALU_SRLV, 32'h00000024, 32'h00000100, 5'd0,  32'h00000010, 1'b0});
        vecs.push_back('{"srav",      ALU_SRAV, 32'h00000021, 32'h80000000, 5'd0,  32'hC0000000, 1'b0});
        vecs.push_back('{"lui",       ALU_LUI,  32'h00000000, 32'h00001234, 5'd0,  32'h12340000, 1'b0});
        vecs.push_back('{"lui_hi",    ALU_LUI,  32'h00000000, 32'hFFFF1234, 5'd0,  32'h12340000, 1'b0});
        vecs.push_back('{"none",      ALU_NONE, 32'h00000005, 32'h00000005, 5'd3,  32'h00000000, 1'b1});

        reset = 1'b1;
        alu_control = ALU_NONE;
        alu_a = '0; alu_b = '0; alu_sa = '0;
        rf_write_enable = 1'b0; rf_write_addr = '0; rf_write_data = '0;
        rf_read_addr_a = 5'd2; rf_read_addr_b = 5'd7;
`ifdef MIPS_CPU_HILO_EN
        hilo_op = HILO_NONE;
`endif
        tick();
        tick();
        reset = 1'b0;

        check("reset_v0",    register_v0,    32'h0);
        check("reset_rd_a",  rf_read_data_a, 32'h0);
        check("reset_rd_b",  rf_read_data_b, 32'h0);

        write_reg(5'd2, 32'h12345678);
        rf_read_addr_b = 5'd2;
        #1;
        check("v0_after_write", register_v0,    32'h12345678);
        check("rd_b_r2",        rf_read_data_b, 32'h12345678);

        write_reg(5'd0, 32'hDEADBEEF);
        rf_read_addr_a = 5'd0;
        #1;
        check("r0_hardwired", rf_read_data_a, 32'h0);

        write_reg(5'd5, 32'h00000055);
        rf_read_addr_a = 5'd5;
        #1;
        check("r5_written", rf_read_data_a, 32'h00000055);
        reset = 1'b1;
        write_reg(5'd5, 32'h00000099);
        reset = 1'b0;
        #1;
        check("reset_beats_write", rf_read_data_a, 32'h0);
        check("reset_clears_v0",   register_v0,    32'h0);

        write_reg(5'd7, 32'h00000011);
        rf_read_addr_a  = 5'd7;
        rf_write_enable = 1'b1;
        rf_write_addr   = 5'd7;
        rf_write_data   = 32'h000000AA;
        #1;
        check("no_bypass_old", rf_read_data_a, 32'h00000011);
        tick();
        rf_write_enable = 1'b0;
        check("new_after_edge", rf_read_data_a, 32'h000000AA);

        foreach (vecs[i]) begin
            alu_control = vecs[i].op;
            alu_a       = vecs[i].a;
            alu_b       = vecs[i].b;
            alu_sa      = vecs[i].sa;
            #1;
            check({vecs[i].name, "_r"},    alu_r,           vecs[i].exp_r);
            check({vecs[i].name, "_zero"}, {31'b0, alu_zero}, {31'b0, vecs[i].exp_zero});
        end

`ifdef MIPS_CPU_HILO_EN
        check("hilo_reset_hi", hi, 32'h0);
        check("hilo_reset_lo", lo, 32'h0);
        alu_a = 32'hFFFFFFFE; alu_b = 32'h00000003; hilo_op = HILO_MULT;
        tick();
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        alu_a = 32'hFFFFFFFE; alu_b = 32'h00000003; hilo_op = HILO_MULTU;
        tick();
        check("multu_hi", hi, 32'h00000002);
        check("multu_lo", lo, 32'hFFFFFFFA);
        alu_a = 32'h00000007; alu_b = 32'hFFFFFFFE; hilo_op = HILO_DIV;
        tick();
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'h00000001);
        alu_a = 32'h00000007; alu_b = 32'h00000000; hilo_op = HILO_DIVU;
        tick();
        check("divu0_lo", lo, 32'hFFFFFFFD);
        check("divu0_hi", hi, 32'h00000001);
        alu_a = 32'h00000011; alu_b = 32'h00000005; hilo_op = HILO_DIVU;
        tick();
        check("divu_lo", lo, 32'h00000003);
        check("divu_hi", hi, 32'h00000002);
        alu_a = 32'hCAFEF00D; hilo_op = HILO_MTHI;
        tick();
        alu_a = 32'h0BADBEEF; hilo_op = HILO_MTLO;
        tick();
        hilo_op = HILO_NONE;
        check("mthi", hi, 32'hCAFEF00D);
        check("mtlo", lo, 32'h0BADBEEF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
